hazard_control_unit: RTL and testbench

- Producer/stall side of the operand-hazard protocol; the forwarding logic resolves everything else.
- Detects hazards that forwarding cannot resolve:
  - load-use: a load in EX feeding the decode-stage instruction;
  - I-cache / D-cache miss waits;
  - taken-branch redirects.
- Drives per-stage pipeline-register load enables, flush/bubble controls, and saturating stall/flush performance counters.
- Sits beside the datapath in the top-level CPU, next to the forwarding unit.

---
 rtl/rv32i_types.sv | 18 +
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_control_unit.sv | 177 +++++++++++++++++
 tb/tb_hazard_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// rv32i_types
//   Shared RV32I pipeline types.
//   rv32i_reg       : architectural register index (x0..x31).
//   hazard_state_t  : hazard control FSM state.
//                     RUN    = pipeline flowing.
//                     FREEZE = whole pipeline held on a cache miss.
// ----------------------------------------------------------------------------
package rv32i_types;

    typedef logic [4:0] rv32i_reg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Event counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-low reset, clears the count
//     inc  : count one event this cycle
//     q    : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] q
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
//   Stall/flush side of the operand-hazard protocol. Handles what the
//   forwarding unit cannot: load-use dependencies, I/D-cache miss waits and
//   taken-branch redirects. Drives pipeline-register enables, flush/bubble
//   controls and three saturating performance counters.
//
//   Ports:
//     clk, rst               : clock, asynchronous active-low reset
//     using_rs1/using_rs2    : decode instruction reads rs1/rs2
//     if_id_rs1/if_id_rs2    : decode source registers
//     id_ex_rd               : EX destination register
//     id_ex_mem_read         : EX instruction is a load
//     br_taken               : EX control transfer redirects the PC
//     imem_req/imem_resp     : fetch request outstanding / I-cache response pulse
//     dmem_req/dmem_resp     : MEM access outstanding / D-cache response pulse
//     pc_load .. mem_wb_load : per-stage register enables
//     if_id_flush            : IF/ID captures a NOP
//     id_ex_bubble           : ID/EX captures a NOP
//     imem_done_q            : fetch data already captured, use buffered copy
//     stall_cnt              : cycles the pipeline was frozen
//     bubble_cnt             : load-use bubbles inserted
//     flush_cnt              : branch flushes performed
// ----------------------------------------------------------------------------
module hazard_control_unit
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 using_rs1,
    input  logic                 using_rs2,
    input  rv32i_reg             if_id_rs1,
    input  rv32i_reg             if_id_rs2,
    input  rv32i_reg             id_ex_rd,
    input  logic                 id_ex_mem_read,
    input  logic                 br_taken,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_flush,
    output logic                 id_ex_bubble,
    output logic                 imem_done_q,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    hazard_state_t state_q, state_d;
    logic          dmem_done_q;
    logic          imem_done_d, dmem_done_d;
    logic          imiss, dmiss, frozen, load_use;
    logic          stall_inc, bubble_inc, flush_inc;

    always_comb begin
        // A miss only counts while its data has not already been captured.
        imiss  = imem_req & ~imem_resp & ~imem_done_q;
        dmiss  = dmem_req & ~dmem_resp & ~dmem_done_q;
        frozen = imiss | dmiss;

        load_use = id_ex_mem_read & (id_ex_rd != 5'd0) &
                   (((id_ex_rd == if_id_rs1) & using_rs1) |
                    ((id_ex_rd == if_id_rs2) & using_rs2));

        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_load   = 1'b0;
        ex_mem_load  = 1'b0;
        mem_wb_load  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        bubble_inc   = 1'b0;
        flush_inc    = 1'b0;
        state_d      = RUN;
        imem_done_d  = imem_done_q;
        dmem_done_d  = dmem_done_q;

        if (frozen) begin
            // Whole pipeline holds; remember any response that arrives while
            // the other side is still waiting.
            state_d     = FREEZE;
            stall_inc   = 1'b1;
            imem_done_d = imem_done_q | imem_resp;
            dmem_done_d = dmem_done_q | dmem_resp;
        end else begin
            // Branch beats load-use: the dependent instruction is flushed anyway.
            // A branch or load-use held through a freeze lands here on the
            // release cycle, since EX did not change while frozen.
            if (br_taken) begin
                pc_load      = 1'b1;
                if_id_load   = 1'b1;
                id_ex_load   = 1'b1;
                ex_mem_load  = 1'b1;
                mem_wb_load  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                flush_inc    = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID one cycle; the load moves to MEM and a
                // NOP enters EX, so detection drops on its own next cycle.
                id_ex_load   = 1'b1;
                ex_mem_load  = 1'b1;
                mem_wb_load  = 1'b1;
                id_ex_bubble = 1'b1;
                bubble_inc   = 1'b1;
            end else begin
                pc_load      = 1'b1;
                if_id_load   = 1'b1;
                id_ex_load   = 1'b1;
                ex_mem_load  = 1'b1;
                mem_wb_load  = 1'b1;
            end

            if (state_q == FREEZE) begin
                imem_done_d = 1'b0;
                dmem_done_d = 1'b0;
            end else begin
                // Buffered data is consumed once its stage advances.
                imem_done_d = pc_load     ? 1'b0 : (imem_done_q | imem_resp);
                dmem_done_d = mem_wb_load ? 1'b0 : (dmem_done_q | dmem_resp);
            end
        end

        // Nothing moves or flushes while reset is held.
        if (!rst) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            mem_wb_load  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bubble_inc),
        .q   (bubble_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

    logic        clk;
    logic        rst;
    logic        using_rs1, using_rs2;
    logic [4:0]  if_id_rs1, if_id_rs2, id_ex_rd;
    logic        id_ex_mem_read, br_taken;
    logic        imem_req, imem_resp, dmem_req, dmem_resp;

    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_bubble, imem_done_q;
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

    logic        s_pc_load, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load;
    logic        s_if_id_flush, s_id_ex_bubble, s_imem_done_q;
    logic [3:0]  s_stall_cnt, s_bubble_cnt, s_flush_cnt;

    logic [7:0]  ctl, s_ctl;
    logic [7:0]  exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // ctl = {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, imem_done_q}
    localparam logic [7:0] C_RUN   = 8'b11111_00_0;
    localparam logic [7:0] C_FRZ   = 8'b00000_00_0;
    localparam logic [7:0] C_FLUSH = 8'b11111_11_0;
    localparam logic [7:0] C_LU    = 8'b00111_01_0;

    assign ctl   = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                    if_id_flush, id_ex_bubble, imem_done_q};
    assign s_ctl = {s_pc_load, s_if_id_load, s_id_ex_load, s_ex_mem_load, s_mem_wb_load,
                    s_if_id_flush, s_id_ex_bubble, s_imem_done_q};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit dut (
        .clk(clk), .rst(rst), .using_rs1(using_rs1), .using_rs2(using_rs2),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .br_taken(br_taken),
        .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .imem_done_q(imem_done_q),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    hazard_control_unit #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .using_rs1(using_rs1), .using_rs2(using_rs2),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .br_taken(br_taken),
        .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pc_load(s_pc_load), .if_id_load(s_if_id_load), .id_ex_load(s_id_ex_load),
        .ex_mem_load(s_ex_mem_load), .mem_wb_load(s_mem_wb_load),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .imem_done_q(s_imem_done_q),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    // stim = {imem_req, imem_resp, dmem_req, dmem_resp, br_taken, id_ex_mem_read}
    task automatic drive(input logic [5:0] s);
        @(posedge clk);
        #1;
        {imem_req, imem_resp, dmem_req, dmem_resp, br_taken, id_ex_mem_read} = s;
    endtask

    task automatic set_decode(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2);
        id_ex_rd  = rd;
        if_id_rs1 = rs1;
        if_id_rs2 = rs2;
        using_rs1 = u1;
        using_rs2 = u2;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        {imem_req, imem_resp, dmem_req, dmem_resp, br_taken, id_ex_mem_read} = '0;
        set_decode(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        {imem_req, imem_resp, dmem_req, dmem_resp, br_taken, id_ex_mem_read} = 6'b000010;
        set_decode(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_tests++;
        if (ctl !== 8'h00) begin n_fail++; $display("FAIL reset_ctl got %b exp %b", ctl, 8'h00); end
        n_tests++;
        if ({stall_cnt, bubble_cnt, flush_cnt} !== 96'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
        end
        n_tests++;
        if ({s_ctl, s_stall_cnt, s_bubble_cnt, s_flush_cnt} !== 20'd0) begin
            n_fail++; $display("FAIL reset_sat got %b %0d exp 0 0", s_ctl, s_stall_cnt);
        end
        br_taken = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        logic [5:0] stim [5];
        logic [4:0] rd [5];
        logic [4:0] rs1 [5];
        logic       u2 [5];
        logic [7:0] expv [5];
        logic [7:0] e;
        stim = '{6'b000001, 6'b000000, 6'b000001, 6'b000001, 6'b000001};
        rd   = '{5'd5, 5'd5, 5'd0, 5'd9, 5'd9};
        rs1  = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd5};
        u2   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        expv = '{C_LU, C_RUN, C_RUN, C_LU, C_RUN};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            set_decode(rd[i], rs1[i], 5'd9, 1'b1, u2[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL load_use cyc%0d got %b exp %b", i, ctl, e); end
            if (i == 1) begin
                n_tests++;
                if (bubble_cnt !== 32'd1) begin n_fail++; $display("FAIL load_use_cnt1 got %0d exp 1", bubble_cnt); end
            end
        end
        drive(6'b000000);
        @(negedge clk);
        n_tests++;
        if (bubble_cnt !== 32'd2) begin n_fail++; $display("FAIL load_use_cnt2 got %0d exp 2", bubble_cnt); end
    endtask

    task automatic test_imiss();
        logic [5:0] stim [5];
        logic [7:0] expv [5];
        logic [7:0] e;
        stim = '{6'b100000, 6'b100000, 6'b100000, 6'b110000, 6'b000000};
        expv = '{C_FRZ, C_FRZ, C_FRZ, C_RUN, C_RUN};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL imiss cyc%0d got %b exp %b", i + 1, ctl, e); end
        end
        n_tests++;
        if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL imiss_stall got %0d exp 3", stall_cnt); end
    endtask

    task automatic test_split_resp();
        logic [5:0] stim [6];
        logic [7:0] expv [6];
        logic [7:0] e;
        stim = '{6'b101000, 6'b111000, 6'b101000, 6'b101000, 6'b101100, 6'b000000};
        expv = '{C_FRZ, C_FRZ, 8'b00000_00_1, 8'b00000_00_1, 8'b11111_00_1, C_RUN};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL split cyc%0d got %b exp %b", i + 1, ctl, e); end
        end
        n_tests++;
        if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL split_stall got %0d exp 4", stall_cnt); end
    endtask

    task automatic test_branch_dmiss();
        logic [5:0] stim [5];
        logic [7:0] expv [5];
        logic [7:0] e;
        stim = '{6'b001010, 6'b001010, 6'b001010, 6'b001110, 6'b000000};
        expv = '{C_FRZ, C_FRZ, C_FRZ, C_FLUSH, C_RUN};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL br_dmiss cyc%0d got %b exp %b", i + 1, ctl, e); end
        end
        n_tests++;
        if ({flush_cnt, stall_cnt, bubble_cnt} !== {32'd1, 32'd3, 32'd0}) begin
            n_fail++; $display("FAIL br_dmiss_cnt got f%0d s%0d b%0d exp f1 s3 b0", flush_cnt, stall_cnt, bubble_cnt);
        end
    endtask

    task automatic test_branch_load_use();
        logic [5:0] stim [2];
        logic [7:0] expv [2];
        logic [7:0] e;
        stim = '{6'b000011, 6'b000000};
        expv = '{C_FLUSH, C_RUN};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            drive(stim[i]);
            set_decode(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL br_lu cyc%0d got %b exp %b", i, ctl, e); end
        end
        n_tests++;
        if ({flush_cnt, bubble_cnt} !== {32'd1, 32'd0}) begin
            n_fail++; $display("FAIL br_lu_cnt got f%0d b%0d exp f1 b0", flush_cnt, bubble_cnt);
        end
    endtask

    task automatic test_load_use_after_freeze();
        logic [5:0] stim [4];
        logic [7:0] expv [4];
        logic [7:0] e;
        stim = '{6'b100001, 6'b100001, 6'b110001, 6'b000000};
        expv = '{C_FRZ, C_FRZ, C_LU, C_RUN};
        apply_reset();
        set_decode(5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL lu_frz cyc%0d got %b exp %b", i + 1, ctl, e); end
        end
        n_tests++;
        if ({bubble_cnt, stall_cnt} !== {32'd1, 32'd2}) begin
            n_fail++; $display("FAIL lu_frz_cnt got b%0d s%0d exp b1 s2", bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_freeze();
        logic [5:0] stim [3];
        logic [7:0] expv [3];
        logic [7:0] e;
        stim = '{6'b101000, 6'b111000, 6'b101000};
        expv = '{C_FRZ, C_FRZ, 8'b00000_00_1};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (ctl !== e) begin n_fail++; $display("FAIL rst_frz cyc%0d got %b exp %b", i + 1, ctl, e); end
        end
        #1;
        br_taken = 1'b1;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({ctl, stall_cnt} !== {8'h00, 32'd0}) begin
            n_fail++; $display("FAIL rst_async got ctl %b stall %0d exp 0 0", ctl, stall_cnt);
        end
        {imem_req, imem_resp, dmem_req, dmem_resp, br_taken, id_ex_mem_read} = '0;
        #1;
        rst = 1'b1;
        drive(6'b000000);
        exp_q.push_back(C_RUN);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if ({ctl, stall_cnt} !== {e, 32'd0}) begin
            n_fail++; $display("FAIL rst_release got ctl %b stall %0d exp %b 0", ctl, stall_cnt, e);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] e;
        apply_reset();
        for (int i = 0; i < 20; i++) drive(6'b100000);
        drive(6'b110000);
        exp_q.push_back(C_RUN);
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if (s_ctl !== e) begin n_fail++; $display("FAIL sat_release got %b exp %b", s_ctl, e); end
        n_tests++;
        if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall4 got %0d exp 15", s_stall_cnt); end
        n_tests++;
        if (stall_cnt !== 32'd20) begin n_fail++; $display("FAIL sat_stall32 got %0d exp 20", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_imiss();
        test_split_resp();
        test_branch_dmiss();
        test_branch_load_use();
        test_load_use_after_freeze();
        test_reset_mid_freeze();
        test_saturation();
        n_tests++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
